ps2_tx: RTL
===========

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clk cycles the PS/2 clock is held low before the start bit (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, watchdog limit in clk cycles per transfer (20 ms at 100 MHz).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 tx_data  input  8  command byte to send to the device.
REQ-006 tx_valid  input  1  request; byte accepted when tx_valid and tx_ready are both high on a rising clk edge.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 ps2_clk  input  1  PS/2 clock line as seen at the pad.
REQ-009 ps2_data  input  1  PS/2 data line as seen at the pad.
REQ-010 ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release (open drain).
REQ-011 ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
REQ-012 tx_done  output  1  one-cycle pulse: byte sent and acknowledged.
REQ-013 tx_err  output  1  one-cycle pulse: transfer failed (no ack or timeout).

Function
REQ-014 ps2_clk and ps2_data SHALL each pass a 3-flop synchronizer; a falling edge SHALL be detected when flop 2 is 0 and flop 3 is 1.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-016 IDLE: both oe low; on accept, tx_data SHALL be latched, odd parity computed (parity = ~^tx_data), and the state SHALL become INHIBIT.
REQ-017 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for INHIBIT_CYCLES cycles; on the final cycle ps2_data_oe SHALL go to 1 (start bit); then REQ.
REQ-018 REQ: ps2_clk_oe=0, ps2_data_oe=1; bit counter cleared; state SHALL become SEND.
REQ-019 SEND: on falling edge n (n=1..8) ps2_data_oe SHALL be driven to ~data[n-1] (LSB first); edge 9 -> ~parity; edge 10 -> 0 (stop bit, line released); then ACK.
REQ-020 Outputs SHALL change in the clk cycle following the detected falling edge and hold until the next one.
REQ-021 ACK: on falling edge 11, synchronized ps2_data 0 SHALL mean acknowledge (-> WAIT_IDLE), 1 SHALL raise tx_err and return to IDLE.
REQ-022 WAIT_IDLE: when synchronized ps2_clk and ps2_data are both 1, tx_done SHALL pulse and the state SHALL become IDLE.
REQ-023 tx_valid outside IDLE SHALL be ignored; the latched byte SHALL not change during a transfer.
REQ-024 tx_done and tx_err SHALL never be high in the same cycle.
REQ-025 Counters SHALL be wide enough for their parameter (ceiling log2) and SHALL not wrap during a transfer.

Reset
REQ-026 While rst_n is low: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_done=0, tx_err=0, counters and synchronizer flops to 1 for line inputs and 0 otherwise.
REQ-027 Reset mid-transfer SHALL release both lines immediately, abort without tx_done or tx_err, and leave the block in IDLE.

Configuration
REQ-028 Macro PS2_TX_TIMEOUT_EN defined: a watchdog SHALL count from leaving INHIBIT; reaching TIMEOUT_CYCLES before IDLE SHALL release both lines, pulse tx_err, return to IDLE.
REQ-029 Macro PS2_TX_TIMEOUT_EN undefined: no watchdog logic; the block SHALL wait indefinitely for device clocks; tx_err only from missing ack.

Verification
REQ-030 Send 0xED, device model clocks at 12.5 kHz and acks -> clk held low 10000 cycles, line bits 0,1,0,1,1,0,1,1,1,1,stop 1, tx_done pulse once, tx_ready back high.
REQ-031 Send 0x07 -> parity bit on line 0; send 0x00 -> parity bit 1.
REQ-032 Device leaves data high on edge 11 -> tx_err pulse, tx_done stays 0, IDLE.
REQ-033 Device never clocks, macro defined, TIMEOUT_CYCLES=5000 -> tx_err at 5000 cycles after REQ, both oe 0; macro undefined -> stays in SEND.
REQ-034 rst_n low after edge 4 -> both oe 0 same cycle, no pulses, next 0xF4 transfer completes normally.
REQ-035 tx_valid held high across a transfer -> exactly one byte per accept, second accept only after tx_done.

Source files
------------

// File: rtl/ps2_tx_if.sv
// Host-side command handshake for ps2_tx: byte + valid/ready in, done/err pulses out.
interface ps2_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, output tx_valid, input tx_ready, input tx_done, input tx_err);
  modport slave  (input tx_data, input tx_valid, output tx_ready, output tx_done, output tx_err);
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte sender (open-drain enables); accepts one byte only while idle, pulses done/err at the end.
// Optional PS2_TX_TIMEOUT_EN adds a per-transfer watchdog that aborts with tx_err after TIMEOUT_CYCLES.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic     clk,
  input  logic     rst_n,
  ps2_tx_if.slave  bus,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  output logic     ps2_clk_oe,
  output logic     ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [3:0]       bit_q, bit_d;
  logic             oe_bit_q, oe_bit_d;
  logic [2:0]       clk_sync_q, dat_sync_q;
  logic             clk_fall, lines_idle, timeout;

  // Index 0 is the first flop; edges come from flops 2 and 3, levels from flop 3.
  assign clk_fall   = ~clk_sync_q[1] & clk_sync_q[2];
  assign lines_idle = clk_sync_q[2] & dat_sync_q[2];

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_run;

  assign wd_run  = (state_q != IDLE) && (state_q != INHIBIT);
  assign timeout = wd_run && (wd_q == WD_LIMIT);
  assign wd_d    = wd_run ? wd_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      parity_q   <= 1'b0;
      inh_q      <= '0;
      bit_q      <= '0;
      oe_bit_q   <= 1'b0;
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      inh_q      <= inh_d;
      bit_q      <= bit_d;
      oe_bit_q   <= oe_bit_d;
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[1:0], ps2_data};
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    parity_d = parity_q;
    inh_d    = inh_q;
    bit_d    = bit_q;
    oe_bit_d = oe_bit_q;
    case (state_q)
      IDLE: begin
        if (bus.tx_valid) begin
          data_d   = bus.tx_data;
          parity_d = ~^bus.tx_data;
          inh_d    = '0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == INH_LAST) state_d = REQ;
        else                   inh_d   = inh_q + 1'b1;
      end
      REQ: begin
        bit_d    = '0;
        oe_bit_d = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        // bit_q holds the number of edges already seen, so edge n drives data[n-1].
        if (clk_fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            oe_bit_d = ~data_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            oe_bit_d = ~parity_q;
          end else begin
            oe_bit_d = 1'b0;
            state_d  = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) state_d = dat_sync_q[2] ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (lines_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  always_comb begin
    bus.tx_ready = (state_q == IDLE);
    ps2_clk_oe   = (state_q == INHIBIT);
    ps2_data_oe  = ((state_q == INHIBIT) && (inh_q == INH_LAST)) ||
                   (state_q == REQ) ||
                   ((state_q == SEND) && oe_bit_q);
    bus.tx_done  = (state_q == WAIT_IDLE) && lines_idle && !timeout;
    bus.tx_err   = ((state_q == ACK) && clk_fall && dat_sync_q[2]) || timeout;
  end

endmodule
